// File: rtl/vpu_cmd_issue.sv
`default_nettype none
// ============================================================================
// Module  : vpu_cmd_issue
// Brief   : CPU-programmed command staging, FIFO queue and issue FSM that
//           hands vertex/attribute commands to the matrix unit.
// Revision: 1.0 - initial release
// ============================================================================
module vpu_cmd_issue #(
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_wr,
    input  logic [3:0]  cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cmd_full,
    output logic [3:0]  cmd_cnt,
    output logic [15:0] v0,
    output logic [15:0] v1,
    output logic [15:0] v2,
    output logic [15:0] v3,
    output logic [15:0] v4,
    output logic [15:0] v5,
    output logic [15:0] v6,
    output logic [15:0] v7,
    output logic [1:0]  obj_type,
    output logic [7:0]  obj_color,
    output logic [4:0]  obj_num,
    output logic [3:0]  gmt_op,
    output logic [3:0]  gmt_code,
    output logic        go,
    input  logic        busy,
    input  logic        obj_mem_full,
    input  logic [4:0]  lst_stored_obj,
    output logic [4:0]  last_obj,
    output logic        mem_full_err,
    output logic        ovf_err,
    output logic        ack_err,
    output logic        idle
);

    localparam int                 c_ptr_w    = $clog2(DEPTH);
    localparam int                 c_tmo_w    = $clog2(ACK_TIMEOUT);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = 1;
    localparam logic [c_tmo_w-1:0] c_tmo_one  = 1;
    // ACK lasts ACK_TIMEOUT-1 cycles, so the GO cycle completes the budget
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(ACK_TIMEOUT - 2);
    localparam logic [3:0]         c_depth    = 4'(DEPTH);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_go   = 2'd1;
    localparam logic [1:0] c_st_ack  = 2'd2;
    localparam logic [1:0] c_st_run  = 2'd3;

    logic [15:0]        r_stg_v [8];
    logic [14:0]        r_stg_attr;
    logic [15:0]        r_fifo_v [DEPTH][8];
    logic [22:0]        r_fifo_attr [DEPTH];
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [3:0]         r_cnt;
    logic [1:0]         r_state;
    logic [c_tmo_w-1:0] r_tmo;
    logic [15:0]        r_cmd_v [8];
    logic [22:0]        r_cmd_attr;
    logic [4:0]         r_last_obj;
    logic               r_mem_full_err;
    logic               r_ovf_err;
    logic               r_ack_err;

    logic w_commit, w_full, w_push, w_ovf, w_clr;
    logic w_ack_tmo, w_run_done, w_pop;

    assign w_full     = (r_cnt == c_depth);
    assign w_commit   = cpu_wr && (cpu_addr == 4'd9);
    assign w_push     = w_commit && !w_full;
    assign w_ovf      = w_commit && w_full;
    assign w_clr      = cpu_wr && (cpu_addr == 4'd15);
    assign w_ack_tmo  = (r_state == c_st_ack) && !busy && (r_tmo == c_tmo_last);
    assign w_run_done = (r_state == c_st_run) && !busy;
    assign w_pop      = w_ack_tmo || w_run_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) r_stg_v[i] <= '0;
            r_stg_attr <= '0;
        end else if (cpu_wr && !cpu_addr[3]) begin
            r_stg_v[cpu_addr[2:0]] <= cpu_wdata;
        end else if (cpu_wr && (cpu_addr == 4'd8)) begin
            r_stg_attr <= cpu_wdata[14:0];
        end
    end

    // Queue storage needs no reset: entries are only read while r_cnt > 0
    always_ff @(posedge clk) begin
        if (w_push) begin
            for (int i = 0; i < 8; i++) r_fifo_v[r_tail][i] <= r_stg_v[i];
            r_fifo_attr[r_tail] <= {cpu_wdata[7:4], cpu_wdata[3:0], r_stg_attr};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + c_ptr_one;
            if (w_pop)  r_head <= r_head + c_ptr_one;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 4'd1;
                2'b01:   r_cnt <= r_cnt - 4'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_st_idle;
            r_tmo          <= '0;
            for (int i = 0; i < 8; i++) r_cmd_v[i] <= '0;
            r_cmd_attr     <= '0;
            r_last_obj     <= '0;
            r_mem_full_err <= 1'b0;
            r_ovf_err      <= 1'b0;
            r_ack_err      <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (r_cnt != 4'd0) begin
                        for (int i = 0; i < 8; i++) r_cmd_v[i] <= r_fifo_v[r_head][i];
                        r_cmd_attr <= r_fifo_attr[r_head];
                        r_state    <= c_st_go;
                    end
                end
                c_st_go: begin
                    r_tmo   <= '0;
                    r_state <= c_st_ack;
                end
                c_st_ack: begin
                    if (busy)           r_state <= c_st_run;
                    else if (w_ack_tmo) r_state <= c_st_idle;
                    else                r_tmo   <= r_tmo + c_tmo_one;
                end
                default: begin
                    if (!busy) begin
                        r_last_obj <= lst_stored_obj;
                        r_state    <= c_st_idle;
                    end
                end
            endcase
            // A set in the same cycle as a clear takes priority
            r_ack_err      <= w_ack_tmo || (r_ack_err && !w_clr);
            r_ovf_err      <= w_ovf || (r_ovf_err && !w_clr);
            r_mem_full_err <= (w_run_done && obj_mem_full) || (r_mem_full_err && !w_clr);
        end
    end

    assign cmd_full     = w_full;
    assign cmd_cnt      = r_cnt;
    assign v0           = r_cmd_v[0];
    assign v1           = r_cmd_v[1];
    assign v2           = r_cmd_v[2];
    assign v3           = r_cmd_v[3];
    assign v4           = r_cmd_v[4];
    assign v5           = r_cmd_v[5];
    assign v6           = r_cmd_v[6];
    assign v7           = r_cmd_v[7];
    assign obj_type     = r_cmd_attr[1:0];
    assign obj_color    = r_cmd_attr[9:2];
    assign obj_num      = r_cmd_attr[14:10];
    assign gmt_op       = r_cmd_attr[18:15];
    assign gmt_code     = r_cmd_attr[22:19];
    // Gated by rst so a reset landing on the GO cycle never emits a start
    assign go           = (r_state == c_st_go) && !rst;
    assign idle         = (r_state == c_st_idle) && (r_cnt == 4'd0);
    assign last_obj     = r_last_obj;
    assign mem_full_err = r_mem_full_err;
    assign ovf_err      = r_ovf_err;
    assign ack_err      = r_ack_err;

endmodule
`default_nettype wire

// File: tb/tb_vpu_cmd_issue.sv
`default_nettype none
// ============================================================================
// Module  : tb_vpu_cmd_issue
// Brief   : Scoreboard bench for vpu_cmd_issue; expected commands are queued
//           at commit and compared field by field on every go pulse.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vpu_cmd_issue;

    typedef struct packed {
        logic [7:0][15:0] v;
        logic [1:0]       typ;
        logic [7:0]       col;
        logic [4:0]       num;
        logic [3:0]       op;
        logic [3:0]       code;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_wr;
    logic [3:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cmd_full;
    logic [3:0]  cmd_cnt;
    logic [15:0] v0, v1, v2, v3, v4, v5, v6, v7;
    logic [1:0]  obj_type;
    logic [7:0]  obj_color;
    logic [4:0]  obj_num;
    logic [3:0]  gmt_op;
    logic [3:0]  gmt_code;
    logic        go;
    logic        busy;
    logic        obj_mem_full;
    logic [4:0]  lst_stored_obj;
    logic [4:0]  last_obj;
    logic        mem_full_err;
    logic        ovf_err;
    logic        ack_err;
    logic        idle;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t stg   = '0;
    exp_t mon_e;
    exp_t exp_q[$];

    vpu_cmd_issue #(.DEPTH(4), .ACK_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cmd_full(cmd_full), .cmd_cnt(cmd_cnt),
        .v0(v0), .v1(v1), .v2(v2), .v3(v3), .v4(v4), .v5(v5), .v6(v6), .v7(v7),
        .obj_type(obj_type), .obj_color(obj_color), .obj_num(obj_num),
        .gmt_op(gmt_op), .gmt_code(gmt_code), .go(go), .busy(busy),
        .obj_mem_full(obj_mem_full), .lst_stored_obj(lst_stored_obj),
        .last_obj(last_obj), .mem_full_err(mem_full_err), .ovf_err(ovf_err),
        .ack_err(ack_err), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every go pulse must match the oldest accepted command
    always @(negedge clk) begin
        if (go) begin
            if (exp_q.size() == 0) begin
                check("unexpected_go", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("v0", v0, mon_e.v[0]);
                check("v1", v1, mon_e.v[1]);
                check("v2", v2, mon_e.v[2]);
                check("v3", v3, mon_e.v[3]);
                check("v4", v4, mon_e.v[4]);
                check("v5", v5, mon_e.v[5]);
                check("v6", v6, mon_e.v[6]);
                check("v7", v7, mon_e.v[7]);
                check("obj_type", obj_type, mon_e.typ);
                check("obj_color", obj_color, mon_e.col);
                check("obj_num", obj_num, mon_e.num);
                check("gmt_op", gmt_op, mon_e.op);
                check("gmt_code", gmt_code, mon_e.code);
            end
        end
    end

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        cpu_wr    = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
        if (a < 4'd8) begin
            stg.v[a[2:0]] = d;
        end else if (a == 4'd8) begin
            stg.typ = d[1:0];
            stg.col = d[9:2];
            stg.num = d[14:10];
        end
        @(negedge clk);
        cpu_wr = 1'b0;
    endtask

    task automatic commit(input logic [3:0] op, input logic [3:0] code, input bit acc);
        exp_t e;
        e      = stg;
        e.op   = op;
        e.code = code;
        if (acc) exp_q.push_back(e);
        wr(4'd9, {8'h00, code, op});
    endtask

    task automatic wait_go(input int max);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            if (go) seen = 1'b1;
        end
        check("go_seen", {31'd0, seen}, 1);
    endtask

    task automatic serve(input int n, input logic mf, input logic [4:0] lst);
        busy = 1'b1;
        repeat (n) @(negedge clk);
        busy           = 1'b0;
        obj_mem_full   = mf;
        lst_stored_obj = lst;
        @(negedge clk);
        obj_mem_full = 1'b0;
    endtask

    task automatic run_cmd(input int n, input logic mf, input logic [4:0] lst);
        wait_go(20);
        serve(n, mf, lst);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        busy = 1'b0; obj_mem_full = 1'b0; lst_stored_obj = '0;
        repeat (3) @(negedge clk);
        check("rst_cnt", cmd_cnt, 0);
        check("rst_idle", idle, 1);
        check("rst_go", go, 0);
        check("rst_full", cmd_full, 0);
        check("rst_v0", v0, 0);
        check("rst_color", obj_color, 0);
        check("rst_last", last_obj, 0);
        check("rst_errs", {29'd0, mem_full_err, ovf_err, ack_err}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic command and go latency
        for (int i = 0; i < 8; i++) wr(4'(i), 16'(16'h1111 * (i + 1)));
        wr(4'd8, 16'h0405);
        commit(4'd1, 4'd2, 1'b1);
        check("lat_go_n1", go, 0);
        check("lat_cnt_n1", cmd_cnt, 1);
        @(negedge clk);
        check("lat_go_n2", go, 1);
        check("lat_v3", v3, 16'h4444);
        serve(4, 1'b0, 5'd3);
        check("t1_last", last_obj, 3);
        check("t1_idle", idle, 1);
        wr(4'd12, 16'hFFFF);
        check("ign_cnt", cmd_cnt, 0);
        check("ign_ovf", ovf_err, 0);

        // Overflow while the matrix unit stays busy
        busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wr(4'd0, 16'(16'hA000 + k));
            commit(4'(k), 4'd5, 1'b1);
        end
        check("ovf_full", cmd_full, 1);
        check("ovf_cnt4", cmd_cnt, 4);
        wr(4'd0, 16'hAFFF);
        commit(4'd9, 4'd5, 1'b0);
        check("ovf_err", ovf_err, 1);
        check("ovf_cnt", cmd_cnt, 4);
        wr(4'd15, 16'h0000);
        check("ovf_clr", ovf_err, 0);
        busy = 1'b0;
        commit(4'hA, 4'd5, 1'b0);
        check("pop_ovf_err", ovf_err, 1);
        repeat (3) run_cmd(3, 1'b0, 5'd2);
        check("t2_idle", idle, 1);

        // Commit alongside a pop with room left
        busy = 1'b1;
        wr(4'd0, 16'hB000);
        commit(4'd1, 4'd6, 1'b1);
        wr(4'd0, 16'hB001);
        commit(4'd2, 4'd6, 1'b1);
        repeat (3) @(negedge clk);
        check("pre_pop_cnt", cmd_cnt, 2);
        wr(4'd0, 16'hB002);
        busy = 1'b0;
        commit(4'd3, 4'd6, 1'b1);
        check("pop_push_cnt", cmd_cnt, 2);
        repeat (2) run_cmd(3, 1'b0, 5'd2);

        // Acknowledge timeout then next queued command
        wr(4'd0, 16'hC000);
        commit(4'd3, 4'd7, 1'b1);
        commit(4'd4, 4'd7, 1'b1);
        check("tmo_go", go, 1);
        repeat (14) @(negedge clk);
        check("tmo_early", ack_err, 0);
        @(negedge clk);
        check("tmo_err", ack_err, 1);
        check("tmo_cnt", cmd_cnt, 1);
        @(negedge clk);
        check("tmo_next_go", go, 1);
        serve(3, 1'b0, 5'd4);

        // Back-to-back spacing, result capture and status clear
        wr(4'd0, 16'hD000);
        commit(4'd5, 4'd8, 1'b1);
        commit(4'd6, 4'd8, 1'b1);
        check("b2b_first_go", go, 1);
        busy = 1'b1;
        repeat (4) @(negedge clk);
        busy = 1'b0;
        lst_stored_obj = 5'd5;
        @(negedge clk);
        check("b2b_gap", go, 0);
        @(negedge clk);
        check("b2b_go", go, 1);
        serve(10, 1'b1, 5'd7);
        check("res_last", last_obj, 7);
        check("res_memfull", mem_full_err, 1);
        wr(4'd15, 16'h0000);
        check("clr_memfull", mem_full_err, 0);
        check("clr_ack", ack_err, 0);
        check("clr_ovf", ovf_err, 0);
        check("clr_last", last_obj, 7);
        check("sb_empty", exp_q.size(), 0);

        // Reset in the middle of a running command
        busy = 1'b1;
        commit(4'd1, 4'd9, 1'b1);
        commit(4'd2, 4'd9, 1'b1);
        commit(4'd3, 4'd9, 1'b1);
        repeat (2) @(negedge clk);
        check("pre_rst_cnt", cmd_cnt, 3);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_cnt", cmd_cnt, 0);
        check("mid_rst_idle", idle, 1);
        check("mid_rst_go", go, 0);
        check("mid_rst_v0", v0, 0);
        check("mid_rst_op", gmt_op, 0);
        check("mid_rst_last", last_obj, 0);
        rst = 1'b0;
        busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_go", go, 0);
        end
        check("post_rst_idle", idle, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vpu_cmd_issue.md
VPU_CMD_ISSUE -- requirements
Module: vpu_cmd_issue

Interface
REQ-001 Parameter DEPTH, default 4, number of queued commands (power of two, 2..8).
REQ-002 Parameter ACK_TIMEOUT, default 15, max cycles from go to observed busy.
REQ-003 clk  in  1  sole clock, all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 cpu_wr  in  1  CPU register write strobe, one word per cycle.
REQ-006 cpu_addr  in  4  register index (0-7 vertex, 8 attr, 9 op/commit, 15 clear status, others ignored).
REQ-007 cpu_wdata  in  16  write data.
REQ-008 cmd_full  out  1  queue holds DEPTH commands.
REQ-009 cmd_cnt  out  4  queued commands, including the one in flight.
REQ-010 v0..v7  out  16 each  vertex words to the matrix unit.
REQ-011 obj_type  out  2; obj_color  out  8; obj_num  out  5; gmt_op  out  4; gmt_code  out  4  command fields to the matrix unit.
REQ-012 go  out  1  one-cycle command start pulse.
REQ-013 busy  in  1  matrix unit busy.
REQ-014 obj_mem_full  in  1; lst_stored_obj  in  5  matrix unit result status.
REQ-015 last_obj  out  5; mem_full_err  out  1; ovf_err  out  1; ack_err  out  1; idle  out  1  status.

Function
REQ-016 Staging: write to addr 0-7 loads vertex register n; addr 8 loads obj_type=[1:0], obj_color=[9:2], obj_num=[14:10].
REQ-017 Write to addr 9 commits: {staged vertices, attr, gmt_op=[3:0], gmt_code=[7:4]} pushed to FIFO tail; staging retained.
REQ-018 Commit while cmd_full: command dropped, ovf_err set, cmd_cnt unchanged (even if a pop occurs the same cycle).
REQ-019 Commit and pop in same cycle (not full): cmd_cnt unchanged; tail and head both advance.
REQ-020 cmd_cnt increments the cycle after commit; pointers wrap modulo DEPTH.
REQ-021 FSM states IDLE, GO, ACK, RUN.
REQ-022 IDLE: if cmd_cnt>0, register head entry onto command outputs, next GO.
REQ-023 GO: go=1 for exactly this cycle, next ACK.
REQ-024 ACK: busy=1 -> RUN; after ACK_TIMEOUT cycles without busy -> set ack_err, pop head, IDLE.
REQ-025 RUN: busy=0 -> pop head, last_obj<=lst_stored_obj, mem_full_err|=obj_mem_full, IDLE.
REQ-026 Command outputs held stable from GO until return to IDLE and beyond until next load.
REQ-027 Latency: commit at cycle N with empty queue and IDLE -> go high at cycle N+2.
REQ-028 Back-to-back: next go no earlier than 2 cycles after busy falls.
REQ-029 idle=1 iff state IDLE and cmd_cnt=0.
REQ-030 Write to addr 15 clears mem_full_err, ovf_err, ack_err; same-cycle set wins over clear.
REQ-031 Writes to addr 10-14 have no effect.

Reset
REQ-032 rst=1: state IDLE, FIFO empty, cmd_cnt=0, go=0, all staging/command outputs 0, last_obj=0, all error flags 0, idle=1.
REQ-033 rst mid-command: in-flight and queued commands discarded, go never asserted during or on the cycle after rst.

Verification
REQ-034 Write v0..v7=0x1111..0x8888, addr8=0x0405, addr9=0x0021 at cycle N -> go at N+2, v3=0x4444, obj_type=1, obj_color=0x01, obj_num=1, gmt_op=1, gmt_code=2.
REQ-035 Commit 5 commands while busy held high, DEPTH=4 -> cmd_full=1 after 4th, 5th dropped, ovf_err=1, cmd_cnt=4.
REQ-036 busy never asserts after go -> ack_err=1 at 15 cycles after go, cmd_cnt decrements, next queued go follows.
REQ-037 busy high 10 cycles, falls with obj_mem_full=1, lst_stored_obj=7 -> last_obj=7, mem_full_err=1; write addr15 -> both errors clear, last_obj stays 7.
REQ-038 Commit same cycle as RUN pop with cmd_cnt=4 -> dropped; with cmd_cnt=2 -> cmd_cnt stays 2.
REQ-039 Assert rst during RUN with 3 queued -> next cycle cmd_cnt=0, idle=1, go=0, outputs 0.
